// File: rtl/receive_data_if.sv
// Consumer-side handshake of the UART receiver: held byte, ready flag and acknowledge.
interface receive_data_if;
  logic [7:0] output_data;
  logic       data_ready;
  logic       data_ack;

  modport master (output output_data, output data_ready, input data_ack);
  modport slave  (input output_data, input data_ready, output data_ack);
endinterface

// File: rtl/receive_data.sv
// UART receiver, 8N1 by default; define RECEIVE_DATA_PARITY_EN for 8E1 with even-parity check.
// Bytes are held for a consumer with a ready/ack handshake plus sticky framing and overrun flags.
module receive_data #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  receive_data_if.master        bus,
  output logic                  recv_led,
  output logic [7:0]            leds,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RECEIVE_DATA_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        led_q, led_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        frame_ok;

`ifdef RECEIVE_DATA_PARITY_EN
  logic        parity_err_q, parity_err_d;
  assign frame_ok = rx_s_q && !parity_err_q;
`else
  assign frame_ok = rx_s_q;
`endif

  // NOTE: synchronizer flops reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // NOTE: every register updates with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      led_q        <= 1'b0;
      fe_q         <= 1'b0;
      ov_q         <= 1'b0;
`ifdef RECEIVE_DATA_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      led_q        <= led_d;
      fe_q         <= fe_d;
      ov_q         <= ov_d;
`ifdef RECEIVE_DATA_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // NOTE: every next-state value takes its hold default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    ready_d      = ready_q;
    led_d        = led_q;
    fe_d         = fe_q;
    ov_d         = ov_q;
`ifdef RECEIVE_DATA_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    if (bus.data_ack && ready_q) ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
`ifdef RECEIVE_DATA_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef RECEIVE_DATA_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef RECEIVE_DATA_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          parity_err_d = rx_s_q ^ (^shift_q);
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (frame_ok) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            led_d   = ~led_q;
            // An ack landing on the completion cycle consumes the old byte, so no overrun.
            if (ready_q && !bus.data_ack) ov_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.output_data = data_q;
  assign bus.data_ready  = ready_q;
  assign leds            = data_q;
  assign recv_led        = led_q;
  assign frame_error     = fe_q;
  assign overrun         = ov_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_receive_data.sv
// Self-checking bench for receive_data: frame-level reference model, per-cycle compare, directed and random frames.
module tb_receive_data;

  localparam int CPB = 16;
`ifdef RECEIVE_DATA_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Result appears after the stop-bit centre plus 2 synchronizer cycles and 1 edge-detect cycle.
  localparam int DONE_N = (NBITS - 1) * CPB + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       recv_led;
  logic [7:0] leds;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  receive_data_if dif ();

  receive_data #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .bus         (dif),
    .recv_led    (recv_led),
    .leds        (leds),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_data;
  logic       m_ready, m_led, m_fe, m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_led   = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok, input bit ack_same);
    if (!ok) begin
      m_fe = 1'b1;
      if (ack_same) m_ready = 1'b0;
    end else begin
      if (m_ready && !ack_same) m_ov = 1'b1;
      m_data  = b;
      m_ready = 1'b1;
      m_led   = ~m_led;
    end
  endtask

  // Outputs settle after the posedge; compare them against the model mid-way through the low phase.
  always @(negedge clk) begin
    #1;
    check("output_data", dif.output_data, m_data);
    check("leds",        leds,            m_data);
    check("data_ready",  dif.data_ready,  m_ready);
    check("recv_led",    recv_led,        m_led);
    check("frame_error", frame_error,     m_fe);
    check("overrun",     overrun,         m_ov);
  end

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic ack_pulse();
    dif.data_ack = 1'b1;
    @(negedge clk);
    dif.data_ack = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; rst_at >= 0 asserts rst for 3 cycles at that offset.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input bit ack_end, input int rst_at);
    logic [10:0] bits;
    bit          was_reset;
    bit          ok;
    was_reset = 1'b0;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = (^b) ^ ~par_ok;
    bits[NBITS-1] = stop_ok;
`ifdef RECEIVE_DATA_PARITY_EN
    ok = stop_ok && par_ok;
`else
    ok = stop_ok;
`endif
    for (int n = 0; n < NBITS * CPB; n++) begin
      rx = bits[n / CPB];
      if (n == rst_at) begin
        rst = 1'b1;
        model_reset();
        was_reset = 1'b1;
      end
      if (rst_at >= 0 && n == rst_at + 3) rst = 1'b0;
      if (ack_end && n == DONE_N - 1) dif.data_ack = 1'b1;
      if (n == DONE_N) begin
        dif.data_ack = 1'b0;
        if (!was_reset) model_byte(b, ok, ack_end);
      end
      if (n == 3 * CPB) check("busy_mid_frame", busy, 1);
      @(negedge clk);
    end
    rx = 1'b1;
    check("busy_after_frame", busy, 0);
  endtask

  task automatic glitch();
    rx = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (n == 5) rx = 1'b1;
      if (n == 4) check("busy_during_glitch", busy, 1);
      @(negedge clk);
    end
    check("busy_after_glitch", busy, 0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rs, rp, ra;
    int         sel;

    rst = 1'b1;
    rx  = 1'b1;
    dif.data_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_output_data", dif.output_data, 8'h00);
    check("reset_leds",        leds,            8'h00);
    check("reset_data_ready",  dif.data_ready,  0);
    check("reset_recv_led",    recv_led,        0);
    check("reset_frame_error", frame_error,     0);
    check("reset_overrun",     overrun,         0);
    check("reset_busy",        busy,            0);
    rst = 1'b0;
    idle(4);

    // Good byte
    send_frame(8'hA5, 1, 1, 0, -1);
    check("a5_output_data", dif.output_data, 8'hA5);
    check("a5_leds",        leds,            8'hA5);
    check("a5_data_ready",  dif.data_ready,  1);
    check("a5_recv_led",    recv_led,        1);
    check("a5_frame_error", frame_error,     0);

    // Stop bit low: byte discarded
    send_frame(8'h3C, 0, 1, 0, -1);
    idle(8);
    check("3c_frame_error", frame_error,     1);
    check("3c_output_data", dif.output_data, 8'hA5);
    check("3c_data_ready",  dif.data_ready,  1);

    ack_pulse();
    check("ack_clears_ready", dif.data_ready, 0);
    ack_pulse();
    idle(3);

    // Two back-to-back bytes without acknowledge
    send_frame(8'h11, 1, 1, 0, -1);
    send_frame(8'h22, 1, 1, 0, -1);
    check("ovr_output_data", dif.output_data, 8'h22);
    check("ovr_data_ready",  dif.data_ready,  1);
    check("ovr_overrun",     overrun,         1);
    ack_pulse();
    check("ovr_ack_ready",   dif.data_ready,  0);
    idle(5);

    glitch();
    idle(5);

    // Reset in the middle of data bit 4 of an 0xFF frame
    send_frame(8'hFF, 1, 1, 0, 5 * CPB + 8);
    idle(10);
    send_frame(8'h5A, 1, 1, 0, -1);
    check("5a_output_data", dif.output_data, 8'h5A);
    check("5a_frame_error", frame_error,     0);
    check("5a_overrun",     overrun,         0);
    idle(4);

`ifdef RECEIVE_DATA_PARITY_EN
    ack_pulse();
    send_frame(8'h07, 1, 0, 0, -1);
    idle(4);
    check("par_bad_frame_error", frame_error,     1);
    check("par_bad_data_ready",  dif.data_ready,  0);
    send_frame(8'h07, 1, 1, 0, -1);
    check("par_good_output_data", dif.output_data, 8'h07);
    check("par_good_data_ready",  dif.data_ready,  1);
    idle(4);
`endif

    // Acknowledge coinciding with completion of a new byte
    do_reset();
    send_frame(8'h81, 1, 1, 0, -1);
    send_frame(8'h42, 1, 1, 1, -1);
    check("ackcomp_output_data", dif.output_data, 8'h42);
    check("ackcomp_data_ready",  dif.data_ready,  1);
    check("ackcomp_overrun",     overrun,         0);
    idle(4);

    // Random frames
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 5) != 0);
      rp  = ($urandom_range(0, 5) != 0);
      ra  = ($urandom_range(0, 7) == 0);
      send_frame(rb, rs, rp, ra, -1);
      sel = $urandom_range(0, 3);
      if (sel == 0) ack_pulse();
      else if (sel == 1) idle($urandom_range(4, 30));
      if (!rs && sel != 1) idle(4);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per UART bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, 8N1 (8E1 with PARITY_EN), LSB first, idle high.
REQ-005 SHALL have port data_ack  input  1  consumer accepts the held byte.
REQ-006 SHALL have port output_data  output  8  last received byte.
REQ-007 SHALL have port data_ready  output  1  high while output_data holds an unacknowledged byte.
REQ-008 SHALL have port recv_led  output  1  toggles once per accepted byte.
REQ-009 SHALL have port leds  output  8  mirror of output_data.
REQ-010 SHALL have port frame_error  output  1  sticky; stop-bit (or parity) failure seen.
REQ-011 SHALL have port overrun  output  1  sticky; byte completed while data_ready high.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all logic uses synchronized rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
REQ-015 IDLE -> START on falling edge of rx_s (high to low); bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles (integer division) rx_s resampled; low -> DATA, high -> IDLE (glitch rejected, no flags).
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles after mid-start point; shift into shift register LSB first; after 8th sample -> PARITY or STOP.
REQ-018 PARITY: one sample CLKS_PER_BIT later; mismatch against even parity of the 8 data bits recorded as pending error.
REQ-019 STOP: one sample CLKS_PER_BIT later; stop bit low or pending parity error -> frame_error set, byte discarded, output_data/data_ready/recv_led unchanged; then IDLE.
REQ-020 Good stop bit: in the same cycle output_data and leds load the shift register, data_ready set, recv_led toggles; next state IDLE (byte visible one cycle after stop sample).
REQ-021 Good byte with data_ready already high: overwrite output_data, keep data_ready high, set overrun.
REQ-022 data_ack high while data_ready high clears data_ready next cycle; data_ack with data_ready low has no effect.
REQ-023 Simultaneous data_ack and good byte completion: new byte loaded, data_ready stays high, overrun NOT set.
REQ-024 frame_error and overrun clear only on rst.
REQ-025 Baud counter width SHALL be 16 bits; no wrap beyond CLKS_PER_BIT-1.
REQ-026 Back-to-back frames: falling edge detected in IDLE immediately after STOP is accepted with no idle gap required beyond the stop sample.

Reset
REQ-027 rst asserted SHALL immediately force state IDLE, all counters 0, shift register 0, synchronizer flops 1.
REQ-028 Output reset values: output_data 0, leds 0, data_ready 0, recv_led 0, frame_error 0, overrun 0, busy 0.
REQ-029 rst mid-frame SHALL abandon the frame; after release, reception resumes only on a new falling edge.

Configuration
REQ-030 Macro RECEIVE_DATA_PARITY_EN defined: frame is 8E1, PARITY state present, parity failure reported via frame_error per REQ-019.
REQ-031 Macro undefined: frame is 8N1, PARITY state and parity logic absent, DATA -> STOP directly.

Verification (CLKS_PER_BIT=16 on bench)
REQ-032 Send 0xA5 with good stop -> output_data=0xA5, leds=0xA5, data_ready=1, recv_led 0->1, frame_error=0.
REQ-033 Send 0x3C with stop bit low -> frame_error=1, output_data remains previous value, data_ready unchanged.
REQ-034 Send 0x11 then 0x22 without data_ack -> output_data=0x22, data_ready=1, overrun=1; then pulse data_ack -> data_ready=0 next cycle.
REQ-035 Low pulse of 5 cycles on idle rx -> state returns IDLE, no flags, busy low within 12 cycles.
REQ-036 Assert rst at bit 4 of 0xFF frame, release, send 0x5A -> output_data=0x5A, frame_error=0, overrun=0.
REQ-037 With RECEIVE_DATA_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> frame_error=1; with parity bit 1 -> output_data=0x07, data_ready=1.
